// File: rtl/vec_alu_iter.sv
// Lane-parallel vector ALU: single-cycle logic/arith ops plus iterative restoring
// divide, modulo and square root, with one instruction in flight at a time.
module vec_alu_iter #(
    parameter int          DATA_W  = 64,
    parameter logic [5:0]  ALU_OPC = 6'b101010
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        Op_code,
    input  logic [5:0]        R_ins,
    input  logic [1:0]        WW,
    input  logic [DATA_W-1:0] rA_val,
    input  logic [DATA_W-1:0] rB_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALU_out,
    output logic              dbz
);

    localparam logic [5:0] F_AND  = 6'b000001;
    localparam logic [5:0] F_OR   = 6'b000010;
    localparam logic [5:0] F_XOR  = 6'b000011;
    localparam logic [5:0] F_NOT  = 6'b000100;
    localparam logic [5:0] F_MOV  = 6'b000101;
    localparam logic [5:0] F_ADD  = 6'b000110;
    localparam logic [5:0] F_SUB  = 6'b000111;
    localparam logic [5:0] F_RTTH = 6'b001101;
    localparam logic [5:0] F_DIV  = 6'b001110;
    localparam logic [5:0] F_MOD  = 6'b001111;
    localparam logic [5:0] F_SQRT = 6'b010010;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_HOLD = 2'd2} state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_a, r_b, r_q, r_r;
    logic [5:0]          r_func;
    logic [1:0]          r_ww;
    logic [6:0]          r_cnt;
    logic                r_dbz_pend;
    logic                w_accept, w_opc_ok, w_iter_in, w_is_sqrt, w_last;
    logic [6:0]          w_steps;
    logic [DATA_W-1:0]   w_result;
    logic [3:0][DATA_W-1:0] w_add, w_sub, w_rot, w_dq, w_dr, w_sq, w_sr;
    logic [3:0]          w_bz;

    assign w_accept  = in_valid & in_ready;
    assign w_opc_ok  = (Op_code == ALU_OPC);
    assign w_iter_in = w_opc_ok & ((R_ins == F_DIV) | (R_ins == F_MOD) | (R_ins == F_SQRT));
    assign w_is_sqrt = (r_func == F_SQRT);
    assign w_steps   = w_is_sqrt ? (7'd4 << r_ww) : (7'd8 << r_ww);
    assign w_last    = (r_cnt == (w_steps - 7'd1));

    // One restoring step per lane for every lane width; the active width is muxed later.
    // A lane's operand shifts in from r_a's lane MSBs, so bits leaking across lanes are never consumed.
    genvar gw, gl;
    for (gw = 0; gw < 4; gw++) begin : g_w
        localparam int LW = 8 << gw;
        localparam int NL = DATA_W / LW;
        logic [NL-1:0] w_lz;
        for (gl = 0; gl < NL; gl++) begin : g_l
            logic [LW-1:0] w_la, w_lb, w_lq, w_lr, w_ddif, w_sdif;
            logic [LW:0]   w_dsh;
            logic [LW+1:0] w_ssh, w_strial;
            logic          w_dge, w_sge;
            assign w_la     = r_a[gl*LW +: LW];
            assign w_lb     = r_b[gl*LW +: LW];
            assign w_lq     = r_q[gl*LW +: LW];
            assign w_lr     = r_r[gl*LW +: LW];
            assign w_dsh    = {w_lr, w_la[LW-1]};
            assign w_dge    = (w_dsh >= {1'b0, w_lb});
            assign w_ddif   = w_dsh[LW-1:0] - w_lb;
            assign w_ssh    = {w_lr, w_la[LW-1:LW-2]};
            assign w_strial = {w_lq, 2'b01};
            assign w_sge    = (w_ssh >= w_strial);
            assign w_sdif   = w_ssh[LW-1:0] - w_strial[LW-1:0];
            assign w_dq[gw][gl*LW +: LW]  = {w_lq[LW-2:0], w_dge};
            assign w_dr[gw][gl*LW +: LW]  = w_dge ? w_ddif : w_dsh[LW-1:0];
            assign w_sq[gw][gl*LW +: LW]  = {w_lq[LW-2:0], w_sge};
            assign w_sr[gw][gl*LW +: LW]  = w_sge ? w_sdif : w_ssh[LW-1:0];
            assign w_add[gw][gl*LW +: LW] = w_la + w_lb;
            assign w_sub[gw][gl*LW +: LW] = w_la - w_lb;
            assign w_rot[gw][gl*LW +: LW] = {w_la[LW/2-1:0], w_la[LW-1:LW/2]};
            assign w_lz[gl] = (rB_val[gl*LW +: LW] == {LW{1'b0}});
        end
        assign w_bz[gw] = |w_lz;
    end

    // Result selection from latched operands or finished iteration registers.
    always_comb begin
        w_result = {DATA_W{1'b0}};
        case (r_func)
            F_AND:   w_result = r_a & r_b;
            F_OR:    w_result = r_a | r_b;
            F_XOR:   w_result = r_a ^ r_b;
            F_NOT:   w_result = ~r_a;
            F_MOV:   w_result = r_a;
            F_ADD:   w_result = w_add[r_ww];
            F_SUB:   w_result = w_sub[r_ww];
            F_RTTH:  w_result = w_rot[r_ww];
            F_DIV:   w_result = r_q;
            F_MOD:   w_result = r_r;
            F_SQRT:  w_result = r_q;
            default: w_result = {DATA_W{1'b0}};
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = w_iter_in ? S_EXEC : S_HOLD;
                else          w_state_nxt = S_IDLE;
            end
            S_EXEC: begin
                if (w_last) w_state_nxt = S_HOLD;
                else        w_state_nxt = S_EXEC;
            end
            S_HOLD: begin
                if (out_valid && out_ready) w_state_nxt = S_IDLE;
                else                        w_state_nxt = S_HOLD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and the registered result handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            ALU_out    <= {DATA_W{1'b0}};
            dbz        <= 1'b0;
            r_cnt      <= 7'd0;
            r_a        <= {DATA_W{1'b0}};
            r_b        <= {DATA_W{1'b0}};
            r_q        <= {DATA_W{1'b0}};
            r_r        <= {DATA_W{1'b0}};
            r_func     <= 6'd0;
            r_ww       <= 2'd0;
            r_dbz_pend <= 1'b0;
        end else begin
            in_ready <= (w_state_nxt == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a        <= rA_val;
                        r_b        <= rB_val;
                        r_q        <= {DATA_W{1'b0}};
                        r_r        <= {DATA_W{1'b0}};
                        r_cnt      <= 7'd0;
                        r_ww       <= WW;
                        r_func     <= w_opc_ok ? R_ins : 6'd0;
                        r_dbz_pend <= w_opc_ok & ((R_ins == F_DIV) | (R_ins == F_MOD)) & w_bz[WW];
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt + 7'd1;
                    if (w_is_sqrt) begin
                        r_a <= r_a << 2;
                        r_q <= w_sq[r_ww];
                        r_r <= w_sr[r_ww];
                    end else begin
                        r_a <= r_a << 1;
                        r_q <= w_dq[r_ww];
                        r_r <= w_dr[r_ww];
                    end
                end
                S_HOLD: begin
                    if (!out_valid) begin
                        ALU_out   <= w_result;
                        dbz       <= r_dbz_pend;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_alu_iter.sv
// Directed and randomized checks of vec_alu_iter against a per-lane arithmetic reference.
module tb_vec_alu_iter;

    localparam logic [5:0] OPC = 6'b101010;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready, dbz;
    logic [5:0]  Op_code, R_ins;
    logic [1:0]  WW;
    logic [63:0] rA_val, rB_val, ALU_out;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    vec_alu_iter #(.DATA_W(64), .ALU_OPC(OPC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Op_code(Op_code), .R_ins(R_ins), .WW(WW), .rA_val(rA_val), .rB_val(rB_val),
        .out_valid(out_valid), .out_ready(out_ready), .ALU_out(ALU_out), .dbz(dbz)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [5:0] opc, input logic [5:0] f,
                                              input logic [1:0] ww, input logic [63:0] a,
                                              input logic [63:0] b, output logic dz);
        int w, n;
        longint unsigned mask, x, y, r, t;
        logic [63:0] res;
        dz = 1'b0;
        res = 64'd0;
        w = 8 << ww;
        n = 64 / w;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        if (opc != OPC) return 64'd0;
        case (f)
            6'd1: return a & b;
            6'd2: return a | b;
            6'd3: return a ^ b;
            6'd4: return ~a;
            6'd5: return a;
            6'd6, 6'd7, 6'd13, 6'd14, 6'd15, 6'd18: begin
                for (int i = 0; i < n; i++) begin
                    x = (a >> (i * w)) & mask;
                    y = (b >> (i * w)) & mask;
                    r = 64'd0;
                    case (f)
                        6'd6:  r = x + y;
                        6'd7:  r = x - y;
                        6'd13: r = (x >> (w / 2)) | (x << (w / 2));
                        6'd14: begin
                            r = (y == 0) ? mask : x / y;
                            if (y == 0) dz = 1'b1;
                        end
                        6'd15: begin
                            r = (y == 0) ? x : x % y;
                            if (y == 0) dz = 1'b1;
                        end
                        default: begin
                            for (int bt = w / 2 - 1; bt >= 0; bt--) begin
                                t = r | (64'd1 << bt);
                                if (t * t <= x) r = t;
                            end
                        end
                    endcase
                    res = res | ((r & mask) << (i * w));
                end
                return res;
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [5:0] opc, input logic [5:0] f, input logic [1:0] ww);
        if (opc == OPC && (f == 6'd14 || f == 6'd15)) return (8 << ww) + 1;
        if (opc == OPC && f == 6'd18) return (4 << ww) + 1;
        return 1;
    endfunction

    task automatic run_op(input string tag, input logic [5:0] opc, input logic [5:0] f,
                          input logic [1:0] ww, input logic [63:0] a, input logic [63:0] b,
                          input int hold);
        logic [63:0] exp_out;
        logic        exp_dz;
        int          lat;
        exp_out = ref_model(opc, f, ww, a, b, exp_dz);
        chk({tag, "/ready_before"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; Op_code = opc; R_ins = f; WW = ww; rA_val = a; rB_val = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rA_val = 64'd0; rB_val = 64'd0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/latency"}, 64'(lat), 64'(ref_lat(opc, f, ww)));
        chk({tag, "/result"}, ALU_out, exp_out);
        chk({tag, "/dbz"}, {63'd0, dbz}, {63'd0, exp_dz});
        repeat (hold) begin
            @(posedge clk); #1;
            chk({tag, "/hold_valid"}, {63'd0, out_valid}, 64'd1);
            chk({tag, "/hold_result"}, ALU_out, exp_out);
            chk({tag, "/hold_dbz"}, {63'd0, dbz}, {63'd0, exp_dz});
            chk({tag, "/hold_ready"}, {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "/valid_after"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "/ready_after"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [5:0]  codes [14];
        logic [5:0]  f, opc;
        logic [1:0]  ww;
        logic [63:0] a, b, m;
        int          w, k;
        codes = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd13, 6'd14, 6'd15, 6'd18, 6'd0, 6'd8, 6'd63};
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Op_code = 6'd0; R_ins = 6'd0; WW = 2'd0; rA_val = 64'd0; rB_val = 64'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset/out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset/alu_out", ALU_out, 64'd0);
        chk("reset/dbz", {63'd0, dbz}, 64'd0);
        chk("reset/in_ready", {63'd0, in_ready}, 64'd1);

        run_op("vand", OPC, 6'd1, 2'd0, 64'd15, 64'd14, 0);
        chk("vand/const", ALU_out, 64'd14);
        run_op("vadd8", OPC, 6'd6, 2'd0, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111, 0);
        chk("vadd8/const", ALU_out, 64'hFFFFFFFF_10101010);
        run_op("vdiv64", OPC, 6'd14, 2'd3, 64'd102, 64'd10, 0);
        chk("vdiv64/const", ALU_out, 64'd10);
        run_op("vmod64", OPC, 6'd15, 2'd3, 64'd102, 64'd10, 0);
        chk("vmod64/const", ALU_out, 64'd2);
        run_op("vdiv32z", OPC, 6'd14, 2'd2, 64'h00000064_00000007, 64'h00000000_00000002, 0);
        chk("vdiv32z/const", ALU_out, 64'hFFFFFFFF_00000003);
        run_op("vmod16z", OPC, 6'd15, 2'd1, 64'h1234_0064_0007_FFFF, 64'h0000_0009_0002_0000, 1);
        run_op("vsqrt64", OPC, 6'd18, 2'd3, 64'h40, 64'hDEAD, 5);
        chk("vsqrt64/const", ALU_out, 64'd8);
        run_op("vsqrt8", OPC, 6'd18, 2'd0, 64'hFF00_0103_0410_51E1, 64'd0, 0);
        run_op("vrtth16", OPC, 6'd13, 2'd1, 64'h1234_5678_9ABC_DEF0, 64'd0, 0);
        run_op("badopc", 6'd0, 6'd1, 2'd0, 64'hFFFF, 64'hFFFF, 0);

        // Reset in the middle of a divide discards it.
        in_valid = 1'b1; Op_code = OPC; R_ins = 6'd14; WW = 2'd3; rA_val = 64'd500; rB_val = 64'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort/out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort/in_ready", {63'd0, in_ready}, 64'd1);
        repeat (70) @(posedge clk);
        #1 chk("abort/no_output", {63'd0, out_valid}, 64'd0);
        run_op("vand_after_abort", OPC, 6'd1, 2'd0, 64'd15, 64'd14, 0);

        for (int it = 0; it < 60; it++) begin
            f   = codes[$urandom_range(0, 13)];
            opc = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : OPC;
            ww  = 2'($urandom_range(0, 3));
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom} >> $urandom_range(0, 40);
            if ($urandom_range(0, 2) == 0) begin
                w = 8 << ww;
                k = $urandom_range(0, 64 / w - 1);
                m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
                b = b & ~(m << (k * w));
            end
            run_op("rand", opc, f, ww, a, b, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
